// File: rtl/input_debouncer.sv
// input_debouncer: conditions a raw, bouncy 1-bit input into a clean level.
// A synchronizer chain feeds a four-state debounce FSM that uses a shared sample counter.
// The FSM also produces registered rise/fall strobes and a one-shot long-press strobe.
module input_debouncer #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 4,
  parameter int unsigned LONG_PRESS_CYCLES = 16,
  parameter int unsigned CNT_WIDTH         = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_in,
  input  logic enable,
  output logic a,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic busy
);

  typedef enum logic [1:0] {
    StIdleLow   = 2'd0,
    StCheckHigh = 2'd1,
    StHeldHigh  = 2'd2,
    StCheckLow  = 2'd3
  } state_e;

  localparam logic [CNT_WIDTH-1:0] DebCnt  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LongCnt = CNT_WIDTH'(LONG_PRESS_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  // Synchronizer chain; its last stage is the sample the FSM acts on.
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;

  // FSM state, shared sample counter and the long-press-fired flag.
  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   w_cnt_nxt;
  logic [CNT_WIDTH-1:0]   w_cnt_inc;
  logic                   r_fired;
  logic                   w_fired_nxt;

  // Registered outputs.
  logic                   r_a;
  logic                   w_a_nxt;
  logic                   r_rise;
  logic                   w_rise_nxt;
  logic                   r_fall;
  logic                   w_fall_nxt;
  logic                   r_long;
  logic                   w_long_nxt;
  logic                   r_busy;
  logic                   w_busy_nxt;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = r_cnt + CntOne;

  // Shift raw_in through the synchronizer; keeps running while enable is low.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Next-state, counter and output decode; everything holds while enable is low.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_fired_nxt = r_fired;
    w_a_nxt     = r_a;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_long_nxt  = 1'b0;

    if (enable) begin
      unique case (r_state)
        StIdleLow: begin
          if (w_s) begin
            w_state_nxt = StCheckHigh;
            w_cnt_nxt   = CntOne;
          end else begin
            w_cnt_nxt   = '0;
          end
        end

        StCheckHigh: begin
          if (!w_s) begin
            // Glitch: drop back without touching the level.
            w_state_nxt = StIdleLow;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DebCnt) begin
            w_state_nxt = StHeldHigh;
            w_a_nxt     = 1'b1;
            w_rise_nxt  = 1'b1;
            w_cnt_nxt   = CntOne;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end

        StHeldHigh: begin
          if (!w_s) begin
            w_state_nxt = StCheckLow;
            w_cnt_nxt   = CntOne;
          end else if (r_cnt < LongCnt) begin
            // Count held cycles, saturating at LongCnt; fire once per press.
            w_cnt_nxt = w_cnt_inc;
            if ((w_cnt_inc == LongCnt) && !r_fired) begin
              w_long_nxt  = 1'b1;
              w_fired_nxt = 1'b1;
            end
          end
        end

        StCheckLow: begin
          if (w_s) begin
            // Release bounce: resume the press; a saturated count prevents a re-fire.
            w_state_nxt = StHeldHigh;
            w_cnt_nxt   = r_fired ? LongCnt : CntOne;
          end else if (r_cnt == DebCnt) begin
            w_state_nxt = StIdleLow;
            w_a_nxt     = 1'b0;
            w_fall_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_fired_nxt = 1'b0;
          end else begin
            w_cnt_nxt   = w_cnt_inc;
          end
        end

        default: begin
          w_state_nxt = StIdleLow;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == StCheckHigh) || (w_state_nxt == StCheckLow);
  end

  // State, counter and registered outputs with asynchronous clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdleLow;
      r_cnt   <= '0;
      r_fired <= 1'b0;
      r_a     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_long  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fired <= w_fired_nxt;
      r_a     <= w_a_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_long  <= w_long_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign a          = r_a;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign long_press = r_long;
  assign busy       = r_busy;

`ifndef SYNTHESIS
  // Strobes are single-cycle and never coincide; busy mirrors the check states.
  a_rise_fall_excl : assert property (@(posedge clock) disable iff (!reset_n)
                                      !(rise && fall));
  a_rise_pulse     : assert property (@(posedge clock) disable iff (!reset_n)
                                      rise |=> !rise);
  a_fall_pulse     : assert property (@(posedge clock) disable iff (!reset_n)
                                      fall |=> !fall);
  a_long_pulse     : assert property (@(posedge clock) disable iff (!reset_n)
                                      long_press |=> !long_press);
  a_busy_state     : assert property (@(posedge clock) disable iff (!reset_n)
                                      busy == ((r_state == StCheckHigh) ||
                                               (r_state == StCheckLow)));
  a_cnt_saturates  : assert property (@(posedge clock) disable iff (!reset_n)
                                      r_cnt <= LongCnt);
`endif

endmodule

// File: tb/tb_input_debouncer.sv
`timescale 1ns/100ps
// Self-checking bench for input_debouncer: directed scenarios plus random stimulus,
// all compared against a run-length reference model of the debounce rules.
module tb_input_debouncer;

  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 16;
  localparam int unsigned CW   = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  logic raw_in  = 1'b0;
  logic enable  = 1'b1;
  logic a, rise, fall, long_press, busy;

  int n_checks = 0;
  int n_fail   = 0;

  input_debouncer #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .CNT_WIDTH        (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .raw_in    (raw_in),
    .enable    (enable),
    .a         (a),
    .rise      (rise),
    .fall      (fall),
    .long_press(long_press),
    .busy      (busy)
  );

  always #1 clock = ~clock;

  // Reference model: s is raw_in delayed SYNC edges; the level flips after DEB+1
  // consecutive enabled samples that disagree with it; long press counts enabled
  // high samples since the press was accepted or since the last low sample.
  bit m_hist[$];
  bit m_a, m_rise, m_fall, m_long, m_fired;
  int m_run, m_hi;

  function automatic void model_reset();
    m_hist.delete();
    for (int i = 0; i < int'(SYNC); i++) m_hist.push_back(1'b0);
    m_a = 0; m_rise = 0; m_fall = 0; m_long = 0; m_fired = 0;
    m_run = 0; m_hi = 0;
  endfunction

  function automatic void model_edge(input bit raw, input bit en);
    bit s;
    s = m_hist.pop_front();
    m_hist.push_back(raw);
    m_rise = 0; m_fall = 0; m_long = 0;
    if (en) begin
      if (s != m_a) begin
        m_run++;
        if (m_run == int'(DEB) + 1) begin
          m_run = 0;
          m_a   = s;
          if (s) begin
            m_rise = 1; m_hi = 1;
          end else begin
            m_fall = 1; m_fired = 0;
          end
        end else if (m_a) begin
          m_hi = 0;
        end
      end else begin
        m_run = 0;
        if (m_a) begin
          m_hi++;
          if (m_hi == int'(LONG) && !m_fired) begin
            m_long = 1; m_fired = 1;
          end
        end
      end
    end
  endfunction

  function automatic logic [4:0] exp_vec();
    return {m_a, m_rise, m_fall, m_long, (m_run != 0)};
  endfunction

  // One clock: model follows the posedge, we return on the negedge for sampling.
  task automatic step();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_edge(raw_in, enable);
    @(negedge clock);
  endtask

  // Return to a settled low level; no comparisons here.
  task automatic settle_low();
    raw_in = 1'b0;
    enable = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_reset();
    #0.2 reset_n = 1'b0;
    raw_in = 1'b1;
    enable = 1'b1;
    model_reset();
    #0.3;
    n_checks++;
    if ({a, rise, fall, long_press, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async: got a/r/f/lp/b=%b expected 00000",
               {a, rise, fall, long_press, busy});
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b expected 00000", i,
                 {a, rise, fall, long_press, busy});
      end
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL reset_release edge %0d: got %b expected %b", e,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
      if (e == 7) begin
        n_checks++;
        if ({a, rise} !== 2'b11) begin
          n_fail++;
          $display("FAIL reset_rise_edge7: got a/rise=%b expected 11", {a, rise});
        end
      end
      if (e == 8) begin
        n_checks++;
        if ({a, rise} !== 2'b10) begin
          n_fail++;
          $display("FAIL reset_rise_edge8: got a/rise=%b expected 10", {a, rise});
        end
      end
    end
  endtask

  task automatic test_glitch();
    int busy_cyc;
    int bad;
    busy_cyc = 0;
    bad = 0;
    settle_low();
    for (int i = 0; i < 13; i++) begin
      raw_in = (i < 3);
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL glitch cyc %0d: got %b expected %b", i,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
      if (busy === 1'b1) busy_cyc++;
      if (a !== 1'b0 || rise !== 1'b0 || fall !== 1'b0 || long_press !== 1'b0) bad++;
    end
    n_checks++;
    if (busy_cyc < 3 || busy_cyc > 4 || bad != 0) begin
      n_fail++;
      $display("FAIL glitch_summary: got busy_cycles=%0d bad=%0d expected 3..4 and 0",
               busy_cyc, bad);
    end
  endtask

  task automatic test_long_press();
    int rise_n, rise_e, long_n, long_e, fall_n, fall_e;
    rise_n = 0; rise_e = -1; long_n = 0; long_e = -1; fall_n = 0; fall_e = -1;
    settle_low();
    raw_in = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL long_press_hold edge %0d: got %b expected %b", e,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
      if (rise === 1'b1) begin rise_n++; rise_e = e; end
      if (long_press === 1'b1) begin long_n++; long_e = e; end
    end
    n_checks++;
    if (rise_n != 1 || rise_e != 7 || long_n != 1 || long_e != 7 + int'(LONG) - 1
        || a !== 1'b1) begin
      n_fail++;
      $display("FAIL long_press_timing: got rise %0d@%0d long %0d@%0d a=%b expected 1@7 1@%0d a=1",
               rise_n, rise_e, long_n, long_e, a, 7 + int'(LONG) - 1);
    end
    raw_in = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL long_press_release edge %0d: got %b expected %b", e,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
      if (fall === 1'b1) begin fall_n++; fall_e = e; end
    end
    n_checks++;
    if (fall_n != 1 || fall_e != 7 || a !== 1'b0) begin
      n_fail++;
      $display("FAIL long_press_fall: got fall %0d@%0d a=%b expected 1@7 a=0",
               fall_n, fall_e, a);
    end
  endtask

  task automatic test_release_bounce();
    int fall_n, fall_e, long_n;
    fall_n = 0; fall_e = -1; long_n = 0;
    settle_low();
    raw_in = 1'b1;
    repeat (10) step();
    for (int e = 1; e <= 20; e++) begin
      raw_in = (e <= 6) ? ((e % 2) == 0) : 1'b0;
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL release_bounce edge %0d: got %b expected %b", e,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
      if (fall === 1'b1) begin fall_n++; fall_e = e; end
      if (long_press === 1'b1) long_n++;
    end
    n_checks++;
    if (fall_n != 1 || fall_e != 13 || long_n != 0 || a !== 1'b0) begin
      n_fail++;
      $display("FAIL release_bounce_summary: got fall %0d@%0d long=%0d a=%b expected 1@13 0 0",
               fall_n, fall_e, long_n, a);
    end
  endtask

  task automatic test_enable_freeze();
    int rise_e;
    rise_e = -1;
    settle_low();
    raw_in = 1'b1;
    repeat (4) step();
    n_checks++;
    if ({a, busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL freeze_entry: got a/busy=%b expected 01", {a, busy});
    end
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      raw_in = (i < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== 5'b00001
          || {a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL freeze_hold cyc %0d: got %b expected 00001 (model %b)", i,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
    end
    enable = 1'b1;
    raw_in = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL freeze_resume edge %0d: got %b expected %b", e,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
      if (rise === 1'b1 && rise_e < 0) rise_e = e;
    end
    n_checks++;
    if (rise_e != 3) begin
      n_fail++;
      $display("FAIL freeze_rise_latency: got edge %0d expected 3", rise_e);
    end
  endtask

  task automatic test_reset_mid_press();
    int rise_e, rise_n;
    rise_e = -1; rise_n = 0;
    settle_low();
    raw_in = 1'b1;
    repeat (10) step();
    n_checks++;
    if (a !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_precond: got a=%b expected 1", a);
    end
    #0.4 reset_n = 1'b0;
    #0.2;
    n_checks++;
    if ({a, rise, fall, long_press, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %b expected 00000",
               {a, rise, fall, long_press, busy});
    end
    model_reset();
    step();
    n_checks++;
    if ({a, rise, fall, long_press, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_reset_hold: got %b expected 00000",
               {a, rise, fall, long_press, busy});
    end
    reset_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL mid_reset_redebounce edge %0d: got %b expected %b", e,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
      if (rise === 1'b1) begin rise_n++; rise_e = e; end
    end
    n_checks++;
    if (rise_n != 1 || rise_e != 7) begin
      n_fail++;
      $display("FAIL mid_reset_rise: got %0d@%0d expected 1@7", rise_n, rise_e);
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    settle_low();
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        raw_in = ~raw_in;
        // Mix short bounces with holds long enough to be accepted and long-pressed.
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(18, 30) : $urandom_range(1, 8);
      end
      hold--;
      enable = ($urandom_range(0, 9) != 0);
      step();
      n_checks++;
      if ({a, rise, fall, long_press, busy} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc %0d: got a/r/f/lp/b=%b expected %b", i,
                 {a, rise, fall, long_press, busy}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_long_press();
    test_release_bounce();
    test_enable_freeze();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
